// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default sizes and Gray/binary pointer
// conversion helpers used by both the read-side and write-side controllers.
package fifo_pkg;

    localparam int WORDSIZE_DEF = 8;
    localparam int ADDRSIZE_DEF = 8;

    // Helpers work on a wide pointer; narrower pointers are zero-extended
    // in and truncated out, which leaves their low bits exact.
    localparam int PTR_MAX = 32;
    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = 1; i < PTR_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchroniser for a Gray pointer crossing into this clock domain.
// Ports: clk, rst_n (async active-low), d (foreign pointer), q (synced).
module sync_w2r #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: syncs wptr, keeps rbin/rptr, flags empty,
// reports a conservative fill level and drives a registered valid/ready stage.
// Ports: rclk, rrst_n, wptr (Gray, foreign), raddr/mem_rdata (memory read),
// rptr (Gray, to write side), rempty, rlevel, rd_valid/rd_data/rd_ready.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [WORDSIZE-1:0] mem_rdata,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rd_valid,
    output logic [WORDSIZE-1:0] rd_data,
    input  logic                rd_ready
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] rlevel_next;
    logic          pop;
    logic          rempty_next;

    sync_w2r #(
        .WIDTH (PW)
    ) u_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr),
        .q     (rq2_wptr)
    );

    // Pop whenever memory has a word and the output stage is free or
    // being drained this cycle (gives one word per cycle when streaming).
    always_comb begin
        pop         = !rempty && (!rd_valid || rd_ready);
        rbinnext    = rbin + PW'(pop);
        rgraynext   = PW'(bin2gray(ptr_t'(rbinnext)));
        // Full-width compare: MSB separates laps, so full never reads empty.
        rempty_next = (rgraynext == rq2_wptr);
        rlevel_next = PW'(gray2bin(ptr_t'(rq2_wptr))) - rbinnext;
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin     <= '0;
            rptr     <= '0;
            rempty   <= 1'b1;
            rlevel   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= rempty_next;
            rlevel <= rlevel_next;
            if (pop) begin
                rd_data  <= mem_rdata;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule
